// File: rtl/control_sequencer_pkg.sv
// Shared constants, state encoding and ALU mapping
// for the hardwired control sequencer.
package control_sequencer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 16;
    localparam int CTL_WIDTH  = 5;

    localparam logic [4:0] OP_ADD  = 5'b01001;
    localparam logic [4:0] OP_SUB  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b01011;
    localparam logic [4:0] OP_OR   = 5'b01101;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;

    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_R3   = 4'd4;
    localparam logic [3:0] ST_R4   = 4'd5;
    localparam logic [3:0] ST_R5   = 4'd6;
    localparam logic [3:0] ST_I3   = 4'd7;
    localparam logic [3:0] ST_I4   = 4'd8;
    localparam logic [3:0] ST_I5   = 4'd9;
    localparam logic [3:0] ST_HALT = 4'd10;
    // T0 entered from an undefined opcode; same controls
    // as T0 plus the Illegal pulse.
    localparam logic [3:0] ST_T0X  = 4'd11;

    typedef enum logic [3:0] {
        S_RST  = ST_RST,
        S_T0   = ST_T0,
        S_T1   = ST_T1,
        S_T2   = ST_T2,
        S_R3   = ST_R3,
        S_R4   = ST_R4,
        S_R5   = ST_R5,
        S_I3   = ST_I3,
        S_I4   = ST_I4,
        S_I5   = ST_I5,
        S_HALT = ST_HALT,
        S_T0X  = ST_T0X
    } state_e;

    function automatic logic [4:0] alu_code(
        input logic [4:0] op
    );
        logic [4:0] code;
        code = ALU_ADD;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// Register field select: picks Ra/Rb/Rc from IR and
// expands it to one-hot load / bus-drive enables.
module control_sequencer_reg_select
    import control_sequencer_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int NR = NUM_REGS
) (
    input  logic [DW-1:0] i_ir,
    input  logic          i_gra,
    input  logic          i_grb,
    input  logic          i_grc,
    input  logic          i_rin,
    input  logic          i_rout,
    output logic [NR-1:0] o_r_in,
    output logic [NR-1:0] o_r_out
);

    logic [3:0]    w_idx;
    logic [NR-1:0] w_onehot;

    // Field mux; priority only matters if the FSM
    // ever raised two selects, which it does not.
    always_comb begin
        w_idx = 4'd0;
        if (i_gra)
            w_idx = i_ir[26:23];
        else if (i_grb)
            w_idx = i_ir[22:19];
        else if (i_grc)
            w_idx = i_ir[18:15];
    end

    assign w_onehot = {{(NR-1){1'b0}}, 1'b1} << w_idx;

    // Gate the decoded index onto the requested vector.
    always_comb begin
        o_r_in  = i_rin  ? w_onehot : '0;
        o_r_out = i_rout ? w_onehot : '0;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the
// datapath: outputs decode purely from state and IR.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int NR = NUM_REGS,
    parameter int CW = CTL_WIDTH
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [DW-1:0] IR,
    input  logic          Mem_Ready,
    output logic          PC_Out,
    output logic          ZLO_Out,
    output logic          MDR_Out,
    output logic          C_Out,
    output logic          MAR_In,
    output logic          PC_In,
    output logic          MDR_In,
    output logic          IR_In,
    output logic          Y_In,
    output logic          Z_In,
    output logic          IncPC,
    output logic          Read,
    output logic [CW-1:0] CONTROL,
    output logic [NR-1:0] R_In,
    output logic [NR-1:0] R_Out,
    output logic          Run,
    output logic          Illegal
);

    state_e     r_state;
    logic [4:0] w_op;
    logic       w_gra;
    logic       w_grb;
    logic       w_grc;
    logic       w_rin;
    logic       w_rout;

    assign w_op = IR[31:27];

    // State register: the sequencer's only storage.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_RST;
        end else begin
            unique case (r_state)
                S_RST:  r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T0X:  r_state <= S_T1;
                S_T1:   r_state <= Mem_Ready ? S_T2 : S_T1;
                S_T2: begin
                    case (w_op)
                        OP_ADD, OP_SUB,
                        OP_AND, OP_OR: r_state <= S_R3;
                        OP_ADDI:       r_state <= S_I3;
                        OP_NOP:        r_state <= S_T0;
                        OP_HALT:       r_state <= S_HALT;
                        default:       r_state <= S_T0X;
                    endcase
                end
                S_R3:   r_state <= S_R4;
                S_R4:   r_state <= S_R5;
                S_R5:   r_state <= S_T0;
                S_I3:   r_state <= S_I4;
                S_I4:   r_state <= S_I5;
                S_I5:   r_state <= S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_RST;
            endcase
        end
    end

    // Per-state control decode.
    always_comb begin
        PC_Out  = 1'b0;
        ZLO_Out = 1'b0;
        MDR_Out = 1'b0;
        C_Out   = 1'b0;
        MAR_In  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        Z_In    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        CONTROL = '0;
        Run     = 1'b1;
        Illegal = 1'b0;
        w_gra   = 1'b0;
        w_grb   = 1'b0;
        w_grc   = 1'b0;
        w_rin   = 1'b0;
        w_rout  = 1'b0;
        unique case (r_state)
            S_RST: ;
            S_T0, S_T0X: begin
                PC_Out  = 1'b1;
                MAR_In  = 1'b1;
                IncPC   = 1'b1;
                Z_In    = 1'b1;
                Illegal = (r_state == S_T0X);
            end
            S_T1: begin
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
            end
            S_T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            S_R3, S_I3: begin
                w_grb  = 1'b1;
                w_rout = 1'b1;
                Y_In   = 1'b1;
            end
            S_R4: begin
                w_grc   = 1'b1;
                w_rout  = 1'b1;
                Z_In    = 1'b1;
                CONTROL = CW'(alu_code(w_op));
            end
            S_I4: begin
                C_Out   = 1'b1;
                Z_In    = 1'b1;
                CONTROL = CW'(ALU_ADD);
            end
            S_R5, S_I5: begin
                ZLO_Out = 1'b1;
                w_gra   = 1'b1;
                w_rin   = 1'b1;
            end
            S_HALT: Run = 1'b0;
            default: Run = 1'b1;
        endcase
    end

    control_sequencer_reg_select #(
        .DW (DW),
        .NR (NR)
    ) u_reg_select (
        .i_ir    (IR),
        .i_gra   (w_gra),
        .i_grb   (w_grb),
        .i_grc   (w_grc),
        .i_rin   (w_rin),
        .i_rout  (w_rout),
        .o_r_in  (R_In),
        .o_r_out (R_Out)
    );

    // Bus contention guard: at most one driver per state.
    always_ff @(posedge Clock) begin
        assert ($onehot0({PC_Out, ZLO_Out, MDR_Out,
                          C_Out, |R_Out}))
        else $error("bus contention in state %0d",
                    r_state);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer:
// expected control words queued per step, checked after the edge.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] IR;
    logic        Mem_Ready;
    logic        PC_Out, ZLO_Out, MDR_Out, C_Out;
    logic        MAR_In, PC_In, MDR_In, IR_In;
    logic        Y_In, Z_In, IncPC, Read;
    logic [4:0]  CONTROL;
    logic [15:0] R_In, R_Out;
    logic        Run, Illegal;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .IR        (IR),
        .Mem_Ready (Mem_Ready),
        .PC_Out    (PC_Out),
        .ZLO_Out   (ZLO_Out),
        .MDR_Out   (MDR_Out),
        .C_Out     (C_Out),
        .MAR_In    (MAR_In),
        .PC_In     (PC_In),
        .MDR_In    (MDR_In),
        .IR_In     (IR_In),
        .Y_In      (Y_In),
        .Z_In      (Z_In),
        .IncPC     (IncPC),
        .Read      (Read),
        .CONTROL   (CONTROL),
        .R_In      (R_In),
        .R_Out     (R_Out),
        .Run       (Run),
        .Illegal   (Illegal)
    );

    typedef struct packed {
        logic        pc_out, zlo_out, mdr_out, c_out;
        logic        mar_in, pc_in, mdr_in, ir_in;
        logic        y_in, z_in, inc_pc, read;
        logic [4:0]  control;
        logic [15:0] r_in, r_out;
        logic        run, illegal;
    } ctl_t;

    typedef enum {
        E_RST, E_T0, E_T0I, E_T1, E_T2,
        E_R3, E_R4, E_R5, E_I3, E_I4, E_I5, E_HALT
    } est_e;

    typedef struct {
        string tag;
        ctl_t  exp;
    } sb_t;

    sb_t q[$];
    int  total = 0;
    int  bad   = 0;

    function automatic ctl_t model(est_e st, logic [31:0] ir);
        ctl_t c;
        logic [15:0] ra, rb, rc;
        c  = '0;
        ra = 16'h0001 << ir[26:23];
        rb = 16'h0001 << ir[22:19];
        rc = 16'h0001 << ir[18:15];
        c.run = 1'b1;
        case (st)
            E_RST: ;
            E_T0, E_T0I: begin
                c.pc_out  = 1'b1;
                c.mar_in  = 1'b1;
                c.inc_pc  = 1'b1;
                c.z_in    = 1'b1;
                c.illegal = (st == E_T0I);
            end
            E_T1: begin
                c.zlo_out = 1'b1;
                c.pc_in   = 1'b1;
                c.read    = 1'b1;
                c.mdr_in  = 1'b1;
            end
            E_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            E_R3, E_I3: begin
                c.r_out = rb;
                c.y_in  = 1'b1;
            end
            E_R4: begin
                c.r_out = rc;
                c.z_in  = 1'b1;
                case (ir[31:27])
                    5'b01010: c.control = 5'd1;
                    5'b01011: c.control = 5'd2;
                    5'b01101: c.control = 5'd3;
                    default:  c.control = 5'd0;
                endcase
            end
            E_I4: begin
                c.c_out = 1'b1;
                c.z_in  = 1'b1;
            end
            E_R5, E_I5: begin
                c.zlo_out = 1'b1;
                c.r_in    = ra;
            end
            E_HALT: c.run = 1'b0;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.pc_out  = PC_Out;
        c.zlo_out = ZLO_Out;
        c.mdr_out = MDR_Out;
        c.c_out   = C_Out;
        c.mar_in  = MAR_In;
        c.pc_in   = PC_In;
        c.mdr_in  = MDR_In;
        c.ir_in   = IR_In;
        c.y_in    = Y_In;
        c.z_in    = Z_In;
        c.inc_pc  = IncPC;
        c.read    = Read;
        c.control = CONTROL;
        c.r_in    = R_In;
        c.r_out   = R_Out;
        c.run     = Run;
        c.illegal = Illegal;
        return c;
    endfunction

    task automatic check();
        sb_t  e;
        ctl_t o;
        total++;
        if (q.size() == 0) begin
            bad++;
            $error("FAIL sb_empty obs=none exp=entry");
        end else begin
            e = q.pop_front();
            o = observe();
            assert (o === e.exp)
            else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h",
                       e.tag, o, e.exp);
            end
        end
    endtask

    // Drive inputs, queue the state expected after the edge,
    // then compare 1 time unit past that edge.
    task automatic step(input logic rst, input logic rdy,
                        input est_e st, input string tag);
        sb_t s;
        Reset     = rst;
        Mem_Ready = rdy;
        s.tag = tag;
        s.exp = model(st, IR);
        q.push_back(s);
        @(posedge Clock);
        #1;
        check();
    endtask

    logic [31:0] alu_irs [2];

    initial begin
        alu_irs[0] = 32'h5292_0000;
        alu_irs[1] = 32'h6A92_0000;
        Reset     = 1'b1;
        Mem_Ready = 1'b1;
        IR        = 32'h4A92_0000;

        // 1: reset, then add R5,R2,R4 with ready memory
        step(1, 1, E_RST, "rst0");
        step(1, 1, E_RST, "rst1");
        step(0, 1, E_T0,  "add_t0");
        step(0, 1, E_T1,  "add_t1");
        step(0, 1, E_T2,  "add_t2");
        step(0, 1, E_R3,  "add_r3");
        step(0, 1, E_R4,  "add_r4");
        step(0, 1, E_R5,  "add_r5");
        step(0, 1, E_T0,  "add_back_t0");

        // 2: same add, 3 wait cycles in T1
        step(0, 0, E_T1,  "wait_t1_a");
        step(0, 0, E_T1,  "wait_t1_b");
        step(0, 0, E_T1,  "wait_t1_c");
        step(0, 0, E_T1,  "wait_t1_d");
        step(0, 1, E_T2,  "wait_t2");
        step(0, 1, E_R3,  "wait_r3");
        step(0, 1, E_R4,  "wait_r4");
        step(0, 1, E_R5,  "wait_r5");
        step(0, 1, E_T0,  "wait_back_t0");

        // SUB and OR: ALU code in R4
        for (int i = 0; i < 2; i++) begin
            IR = alu_irs[i];
            step(0, 1, E_T1, "alu_t1");
            step(0, 1, E_T2, "alu_t2");
            step(0, 1, E_R3, "alu_r3");
            step(0, 1, E_R4, "alu_r4");
            step(0, 1, E_R5, "alu_r5");
            step(0, 1, E_T0, "alu_t0");
        end

        // 3: addi R2,R2,10
        IR = 32'h6110_000A;
        step(0, 1, E_T1, "addi_t1");
        step(0, 1, E_T2, "addi_t2");
        step(0, 1, E_I3, "addi_i3");
        step(0, 1, E_I4, "addi_i4");
        step(0, 1, E_I5, "addi_i5");
        step(0, 1, E_T0, "addi_t0");

        // NOP: straight back to T0
        IR = 32'hD000_0000;
        step(0, 1, E_T1, "nop_t1");
        step(0, 1, E_T2, "nop_t2");
        step(0, 1, E_T0, "nop_t0");

        // 5: undefined opcode, one-cycle Illegal pulse
        IR = 32'hF800_0000;
        step(0, 1, E_T1,  "ill_t1");
        step(0, 1, E_T2,  "ill_t2");
        step(0, 1, E_T0I, "ill_t0");
        step(0, 1, E_T1,  "ill_t1_after");
        step(0, 1, E_T2,  "ill_t2_again");
        step(0, 1, E_T0I, "ill_t0_again");
        step(0, 1, E_T1,  "ill_t1_again");
        // reset with illegal IR: T0 carries no pulse
        step(1, 1, E_RST, "ill_rst");
        step(0, 1, E_T0,  "ill_rst_t0");

        // 4: HALT, 20 idle cycles, reset recovery
        IR = 32'hD800_0000;
        step(0, 1, E_T1, "halt_t1");
        step(0, 1, E_T2, "halt_t2");
        for (int i = 0; i < 20; i++)
            step(0, 1, E_HALT, "halt_idle");
        step(1, 1, E_RST, "halt_rst");
        step(0, 1, E_T0,  "halt_t0");

        // 6: reset during R4
        IR = 32'h4A92_0000;
        step(0, 1, E_T1,  "mid_t1");
        step(0, 1, E_T2,  "mid_t2");
        step(0, 1, E_R3,  "mid_r3");
        step(0, 1, E_R4,  "mid_r4");
        step(1, 1, E_RST, "mid_rst");
        step(0, 1, E_T0,  "mid_t0");
        step(0, 1, E_T1,  "mid2_t1");
        step(0, 1, E_T2,  "mid2_t2");
        step(0, 1, E_R3,  "mid2_r3");
        step(0, 1, E_R4,  "mid2_r4");
        step(0, 1, E_R5,  "mid2_r5");
        step(0, 1, E_T0,  "mid2_t0");

        total++;
        assert (q.size() == 0)
        else begin
            bad++;
            $error("FAIL sb_leftover obs=%0d exp=0",
                   q.size());
        end

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
